bcd_score_counter: RTL and testbench

Parametrised BCD score counter for the scoreboard datapath; successor to the fixed 0–99 up/down counter. It counts rising edges on separate increment and decrement inputs within 0..MAX_VAL, with runtime wrap/saturate mode, synchronous clear and BCD load. Results are presented as registered BCD digits for the display drivers and as binary for the control logic. Boundary hits raise one-cycle overflow and underflow pulses.

---
 rtl/bcd_score_counter.sv | 187 ++++++++++++++++++
 tb/tb_bcd_score_counter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_score_counter.sv
// bcd_score_counter: BCD + binary up/down score counter, range 0..MAX_VAL, wrap or saturate.
// Latency: 1 cycle from a sampled input edge, clear or load to the registered outputs.
// Backpressure: none; input rising edges are consumed every cycle, and an edge that loses to clear or load is dropped.
//
// Ports:
//   clk_i, rst_i (async, active-low)      clock / reset
//   clr_i, load_i, load_val_i             synchronous clear, BCD load (clear wins)
//   inc_i, dec_i, wrap_i                  level inputs; 0->1 edges count, wrap_i selects wrap vs saturate
//   bcd_o, bin_o                          count as BCD digits (digit 0 in [3:0]) and as binary
//   at_max_o, at_min_o                    count == MAX_VAL / count == 0
//   ovf_o, unf_o, load_err_o              one-cycle pulses
module bcd_score_counter #(
  parameter int DIGITS  = 2,
  parameter int MAX_VAL = 99,
  parameter int BW      = 7
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  inc_i,
  input  logic                  dec_i,
  input  logic                  wrap_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   load_val_i,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic [BW-1:0]         bin_o,
  output logic                  at_max_o,
  output logic                  at_min_o,
  output logic                  ovf_o,
  output logic                  unf_o,
  output logic                  load_err_o
);

  localparam int W = 4 * DIGITS;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int           t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int bcd_to_int(input logic [W-1:0] x);
    int v;
    v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      v = v * 10 + int'(x[4*i +: 4]);
    end
    return v;
  endfunction

  function automatic logic digits_ok(input logic [W-1:0] x);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (x[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Ripple +1: a 9 rolls to 0 and passes the carry on.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] x);
    logic [W-1:0] r;
    logic         c;
    r = x;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (x[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = x[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Ripple -1: a 0 rolls to 9 and passes the borrow on.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] x);
    logic [W-1:0] r;
    logic         b;
    r = x;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (x[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = x[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  localparam logic [W-1:0]  MAX_BCD = to_bcd(MAX_VAL);
  localparam logic [BW-1:0] MAX_BIN = BW'(MAX_VAL);

  logic [W-1:0]  r_bcd;
  logic [BW-1:0] r_bin;
  logic          r_inc_q;
  logic          r_dec_q;
  logic          r_ovf;
  logic          r_unf;
  logic          r_load_err;

  logic          w_inc_ev;
  logic          w_dec_ev;
  logic          w_load_ok;
  int            w_load_int;

  always_comb begin
    w_inc_ev   = inc_i & ~r_inc_q;
    w_dec_ev   = dec_i & ~r_dec_q;
    w_load_int = bcd_to_int(load_val_i);
    w_load_ok  = digits_ok(load_val_i) && (w_load_int <= MAX_VAL);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_bcd      <= '0;
      r_bin      <= '0;
      // Reset high so a level already held at release does not count.
      r_inc_q    <= 1'b1;
      r_dec_q    <= 1'b1;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_inc_q    <= inc_i;
      r_dec_q    <= dec_i;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_load_err <= 1'b0;
      if (clr_i) begin
        r_bcd <= '0;
        r_bin <= '0;
      end else if (load_i) begin
        if (w_load_ok) begin
          r_bcd <= load_val_i;
          r_bin <= BW'(w_load_int);
        end else begin
          r_load_err <= 1'b1;
        end
      end else if (w_inc_ev && !w_dec_ev) begin
        if (r_bin == MAX_BIN) begin
          r_ovf <= 1'b1;
          if (wrap_i) begin
            r_bcd <= '0;
            r_bin <= '0;
          end
        end else begin
          r_bcd <= bcd_inc(r_bcd);
          r_bin <= r_bin + BW'(1);
        end
      end else if (w_dec_ev && !w_inc_ev) begin
        if (r_bin == '0) begin
          r_unf <= 1'b1;
          if (wrap_i) begin
            r_bcd <= MAX_BCD;
            r_bin <= MAX_BIN;
          end
        end else begin
          r_bcd <= bcd_dec(r_bcd);
          r_bin <= r_bin - BW'(1);
        end
      end
    end
  end

  assign bcd_o      = r_bcd;
  assign bin_o      = r_bin;
  assign at_max_o   = (r_bin == MAX_BIN);
  assign at_min_o   = (r_bin == '0);
  assign ovf_o      = r_ovf;
  assign unf_o      = r_unf;
  assign load_err_o = r_load_err;

endmodule

// File: tb/tb_bcd_score_counter.sv
module tb_bcd_score_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // DUT A: 2 digits, 0..99
  logic       clr_a = 0, inc_a = 0, dec_a = 0, wrap_a = 0, load_a = 0;
  logic [7:0] lv_a = '0, bcd_a;
  logic [6:0] bin_a;
  logic       amax_a, amin_a, ovf_a, unf_a, lerr_a;

  // DUT B: 2 digits, 0..59
  logic       clr_b = 0, inc_b = 0, dec_b = 0, wrap_b = 0, load_b = 0;
  logic [7:0] lv_b = '0, bcd_b;
  logic [6:0] bin_b;
  logic       amax_b, amin_b, ovf_b, unf_b, lerr_b;

  // DUT C: 3 digits, 0..999
  logic        clr_c = 0, inc_c = 0, dec_c = 0, wrap_c = 0, load_c = 0;
  logic [11:0] lv_c = '0, bcd_c;
  logic [9:0]  bin_c;
  logic        amax_c, amin_c, ovf_c, unf_c, lerr_c;

  bcd_score_counter #(.DIGITS(2), .MAX_VAL(99), .BW(7)) u_a (
    .clk_i(clk), .rst_i(rst), .clr_i(clr_a), .inc_i(inc_a), .dec_i(dec_a),
    .wrap_i(wrap_a), .load_i(load_a), .load_val_i(lv_a), .bcd_o(bcd_a),
    .bin_o(bin_a), .at_max_o(amax_a), .at_min_o(amin_a), .ovf_o(ovf_a),
    .unf_o(unf_a), .load_err_o(lerr_a));

  bcd_score_counter #(.DIGITS(2), .MAX_VAL(59), .BW(7)) u_b (
    .clk_i(clk), .rst_i(rst), .clr_i(clr_b), .inc_i(inc_b), .dec_i(dec_b),
    .wrap_i(wrap_b), .load_i(load_b), .load_val_i(lv_b), .bcd_o(bcd_b),
    .bin_o(bin_b), .at_max_o(amax_b), .at_min_o(amin_b), .ovf_o(ovf_b),
    .unf_o(unf_b), .load_err_o(lerr_b));

  bcd_score_counter #(.DIGITS(3), .MAX_VAL(999), .BW(10)) u_c (
    .clk_i(clk), .rst_i(rst), .clr_i(clr_c), .inc_i(inc_c), .dec_i(dec_c),
    .wrap_i(wrap_c), .load_i(load_c), .load_val_i(lv_c), .bcd_o(bcd_c),
    .bin_o(bin_c), .at_max_o(amax_c), .at_min_o(amin_c), .ovf_o(ovf_c),
    .unf_o(unf_c), .load_err_o(lerr_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] b2(input int v);
    return 32'(((v / 10) << 4) | (v % 10));
  endfunction

  initial begin
    int exp_cnt;

    // Reset with inc held high
    inc_a = 1;
    tick(); tick();
    chk("rst_bcd", 32'(bcd_a), 0);
    chk("rst_bin", 32'(bin_a), 0);
    chk("rst_atmin", 32'(amin_a), 1);
    chk("rst_atmax", 32'(amax_a), 0);
    chk("rst_ovf", 32'(ovf_a), 0);
    chk("rst_unf", 32'(unf_a), 0);
    chk("rst_lerr", 32'(lerr_a), 0);
    rst = 1;
    repeat (5) tick();
    chk("held_inc_no_count", 32'(bcd_a), 0);
    inc_a = 0; tick();
    inc_a = 1; tick();
    chk("fresh_edge_count", 32'(bcd_a), 32'h01);
    inc_a = 0; tick();

    // Load 09, 10 increments to 19
    load_a = 1; lv_a = 8'h09; tick(); load_a = 0;
    chk("load09", 32'(bcd_a), 32'h09);
    exp_cnt = 9;
    for (int k = 0; k < 10; k++) begin
      inc_a = 1; tick();
      exp_cnt++;
      chk("inc_bcd", 32'(bcd_a), b2(exp_cnt));
      chk("inc_bin", 32'(bin_a), 32'(exp_cnt));
      inc_a = 0; tick();
    end
    chk("at19", 32'(bcd_a), 32'h19);

    // 20 decrements with saturate: unf only on the 20th
    wrap_a = 0;
    for (int k = 1; k <= 20; k++) begin
      dec_a = 1; tick();
      exp_cnt = (exp_cnt > 0) ? exp_cnt - 1 : 0;
      chk("dec_bcd", 32'(bcd_a), b2(exp_cnt));
      chk("dec_bin", 32'(bin_a), 32'(exp_cnt));
      chk("dec_unf", 32'(unf_a), (k == 20) ? 32'd1 : 32'd0);
      dec_a = 0; tick();
      chk("dec_unf_clear", 32'(unf_a), 0);
    end
    chk("sat_min_atmin", 32'(amin_a), 1);

    // Wrap at max
    wrap_a = 1;
    load_a = 1; lv_a = 8'h98; tick(); load_a = 0;
    inc_a = 1; tick(); inc_a = 0;
    chk("to99", 32'(bcd_a), 32'h99);
    chk("to99_atmax", 32'(amax_a), 1);
    chk("to99_noovf", 32'(ovf_a), 0);
    tick();
    inc_a = 1; tick(); inc_a = 0;
    chk("wrap_bcd", 32'(bcd_a), 32'h00);
    chk("wrap_ovf", 32'(ovf_a), 1);
    tick();
    chk("wrap_ovf_1cyc", 32'(ovf_a), 0);

    // Saturate at max
    wrap_a = 0;
    load_a = 1; lv_a = 8'h98; tick(); load_a = 0;
    inc_a = 1; tick(); inc_a = 0; tick();
    inc_a = 1; tick(); inc_a = 0;
    chk("sat_bcd", 32'(bcd_a), 32'h99);
    chk("sat_bin", 32'(bin_a), 99);
    chk("sat_ovf", 32'(ovf_a), 1);
    tick();
    chk("sat_ovf_1cyc", 32'(ovf_a), 0);

    // Invalid digit load
    load_a = 1; lv_a = 8'h4A; tick(); load_a = 0;
    chk("bad_digit_keep", 32'(bcd_a), 32'h99);
    chk("bad_digit_err", 32'(lerr_a), 1);
    tick();
    chk("bad_digit_err_1cyc", 32'(lerr_a), 0);

    // Simultaneous inc/dec edges cancel
    load_a = 1; lv_a = 8'h50; tick(); load_a = 0;
    inc_a = 1; dec_a = 1; tick();
    chk("cancel_bcd", 32'(bcd_a), 32'h50);
    chk("cancel_ovf", 32'(ovf_a), 0);
    chk("cancel_unf", 32'(unf_a), 0);
    inc_a = 0; dec_a = 0; tick();

    // Clear beats load and event; the swallowed edge does not recount
    clr_a = 1; load_a = 1; lv_a = 8'h33; inc_a = 1; tick();
    clr_a = 0; load_a = 0;
    chk("clr_prio", 32'(bcd_a), 32'h00);
    tick();
    chk("clr_edge_dropped", 32'(bcd_a), 32'h00);
    inc_a = 0; tick();

    // Wrap underflow
    wrap_a = 1;
    dec_a = 1; tick(); dec_a = 0;
    chk("wrap_unf_bcd", 32'(bcd_a), 32'h99);
    chk("wrap_unf", 32'(unf_a), 1);
    tick();

    // MAX_VAL = 59 instance
    load_b = 1; lv_b = 8'h45; tick(); load_b = 0;
    chk("b_load45", 32'(bcd_b), 32'h45);
    load_b = 1; lv_b = 8'h75; tick(); load_b = 0;
    chk("b_over_keep", 32'(bcd_b), 32'h45);
    chk("b_over_err", 32'(lerr_b), 1);
    tick();
    chk("b_over_err_1cyc", 32'(lerr_b), 0);
    load_b = 1; lv_b = 8'h59; tick(); load_b = 0;
    chk("b_atmax", 32'(amax_b), 1);
    wrap_b = 1; inc_b = 1; tick(); inc_b = 0;
    chk("b_wrap_bcd", 32'(bcd_b), 32'h00);
    chk("b_wrap_ovf", 32'(ovf_b), 1);
    tick();

    // 3-digit instance
    wrap_c = 1;
    load_c = 1; lv_c = 12'h999; tick(); load_c = 0;
    chk("c_load999_bin", 32'(bin_c), 999);
    inc_c = 1; tick(); inc_c = 0;
    chk("c_wrap_bcd", 32'(bcd_c), 32'h000);
    chk("c_wrap_bin", 32'(bin_c), 0);
    chk("c_wrap_ovf", 32'(ovf_c), 1);
    tick();
    load_c = 1; lv_c = 12'h199; tick(); load_c = 0;
    inc_c = 1; tick(); inc_c = 0;
    chk("c_carry2_bcd", 32'(bcd_c), 32'h200);
    chk("c_carry2_bin", 32'(bin_c), 200);
    tick();
    dec_c = 1; tick(); dec_c = 0;
    chk("c_borrow2_bcd", 32'(bcd_c), 32'h199);
    tick();

    // Asynchronous reset mid-cycle, inc held through release
    inc_c = 1;
    #3 rst = 0;
    #1;
    chk("c_async_bcd", 32'(bcd_c), 0);
    chk("c_async_bin", 32'(bin_c), 0);
    chk("c_async_atmin", 32'(amin_c), 1);
    tick();
    rst = 1;
    tick(); tick();
    chk("c_post_rst_no_count", 32'(bcd_c), 0);
    inc_c = 0; tick();
    inc_c = 1; tick();
    chk("c_post_rst_count", 32'(bcd_c), 32'h001);
    inc_c = 0; tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
